// File: rtl/div_unit.sv
// div_unit: iterative restoring divider (DIV/DIVU) beside the ALU, one quotient bit per cycle.
// Ports: clk, rst (sync, active high), start, is_signed, A, B -> busy, done, quotient, remainder, div_by_zero.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |A| < |B|.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic             q_neg;
   logic             r_neg;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   assign a_neg = is_signed & A[WIDTH-1];
   assign b_neg = is_signed & B[WIDTH-1];
   assign abs_a = a_neg ? -A : A;
   assign abs_b = b_neg ? -B : B;

   // Partial remainder is always < divisor, so WIDTH+1 bits hold the
   // shifted value and the MSB of the difference is the borrow.
   assign shifted = {rem, dvd[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvs};

   // busy/done are registered decodes of state, so they trail it by a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         rem         <= '0;
         dvd         <= '0;
         dvs         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= (state != IDLE);
         done <= (state == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  q_neg <= a_neg ^ b_neg;
                  r_neg <= a_neg;
                  count <= '0;
                  if (B == '0) begin
                     quotient    <= '1;
                     remainder   <= A;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     div_by_zero <= 1'b0;
                     dvs         <= abs_b;
`ifdef DIV_EARLY_OUT_EN
                     if (abs_a < abs_b) begin
                        dvd   <= '0;
                        rem   <= abs_a;
                        state <= FIX;
                     end else begin
                        dvd   <= abs_a;
                        rem   <= '0;
                        state <= CALC;
                     end
`else
                     dvd   <= abs_a;
                     rem   <= '0;
                     state <= CALC;
`endif
                  end
               end
            end
            CALC: begin
               rem   <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
               dvd   <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
               count <= count + CW'(1);
               if (count == LAST) state <= FIX;
            end
            FIX: begin
               quotient  <= q_neg ? -dvd : dvd;
               remainder <= r_neg ? -rem : rem;
               state     <= DONE;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed + random scoreboard bench for div_unit.
// Checks results, latency, busy/done timing, reset and ignored starts.
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         is_signed;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;

   always #5 clk = ~clk;

   div_unit #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .is_signed(is_signed),
      .A(A),
      .B(B),
      .busy(busy),
      .done(done),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic s);
      exp_t   e;
      longint sa, sbv, qq, rr;
      if (b == '0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else begin
         if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
         end else begin
            sa  = longint'({32'h0, a});
            sbv = longint'({32'h0, b});
         end
         qq   = sa / sbv;
         rr   = sa % sbv;
         e.q  = qq[W-1:0];
         e.r  = rr[W-1:0];
         e.dz = 1'b0;
      end
      return e;
   endfunction

   function automatic int latency(input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  input logic s);
      logic [W-1:0] ma, mb;
      ma = (s && a[W-1]) ? -a : a;
      mb = (s && b[W-1]) ? -b : b;
      if (b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) return 2;
`else
      if (ma == mb && ma == '0) return 0;
`endif
      return W + 2;
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input int inj);
      exp_t e;
      int   lat;
      bit   seen;
      lat = latency(a, b, s);
      @(negedge clk);
      A         = a;
      B         = b;
      is_signed = s;
      start     = 1'b1;
      sb.push_back(model(a, b, s));
      @(negedge clk);
      start     = 1'b0;
      A         = $urandom;
      B         = $urandom;
      is_signed = ~s;
      if (b != '0) begin
         chk("dz_clear", div_by_zero, 0);
         chk("q_hold", quotient, last_q);
         chk("r_hold", remainder, last_r);
      end
      seen = 1'b0;
      for (int cyc = 1; cyc <= W + 6 && !seen; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         chk("busy", busy, 1);
         if (done) begin
            seen = 1'b1;
            chk("latency", cyc, lat);
            chk("sb_size", sb.size(), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", div_by_zero, e.dz);
               last_q = e.q;
               last_r = e.r;
            end
         end
         if (cyc == inj) begin
            A         = 9;
            B         = 3;
            is_signed = 1'b0;
            start     = 1'b1;
         end
      end
      chk("done_seen", seen, 1);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("busy_drop", busy, 0);
   endtask

   task automatic reset_mid();
      logic any;
      @(negedge clk);
      A         = 100;
      B         = 7;
      is_signed = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_dz", div_by_zero, 0);
      last_q = '0;
      last_r = '0;
      any    = 1'b0;
      repeat (40) begin
         @(negedge clk);
         any = any | done | busy;
      end
      chk("rst_no_done", any, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      A         = '0;
      B         = '0;
      repeat (2) @(negedge clk);
      chk("init_busy", busy, 0);
      chk("init_done", done, 0);
      chk("init_q", quotient, 0);
      chk("init_r", remainder, 0);
      chk("init_dz", div_by_zero, 0);
      rst = 1'b0;

      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      run_op(32'd5, 32'd0, 1'b0, 0);
      run_op(32'd10, 32'd3, 1'b0, 0);
      run_op(32'd5, 32'd0, 1'b1, 0);
      run_op(32'd10, 32'd3, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'd3, 32'd10, 1'b0, 0);
      run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op(32'd100, 32'd7, 1'b0, 5);
      reset_mid();
      run_op(32'd100, 32'd7, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         run_op($urandom, $urandom >> $urandom_range(0, 31),
                1'($urandom_range(0, 1)), 0);
      end
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
